// File: rtl/right_shift_unit.sv
// Multi-cycle right shifter: moves the operand right by up to 3 bits per clock,
// with zero fill (logical) or fill from the captured sign bit (arithmetic).
module right_shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [3:0]       amount,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             fill_q, fill_d;

    logic [1:0]       step;
    logic [3:0]       remAfter;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fillMask;

    // At most three bit positions retire per cycle; the final step takes the leftover.
    assign step     = (remaining_q >= 4'd3) ? 2'd3 : remaining_q[1:0];
    assign remAfter = remaining_q - {2'b00, step};
    assign shifted  = result_q >> step;
    assign fillMask = ~({WIDTH{1'b1}} >> step);

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d    = operand;
                    remaining_d = amount;
                    fill_d      = arith & operand[WIDTH-1];
                    state_d     = (amount == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Fill comes from the sign captured at load, not from the moving register.
                result_d    = fill_q ? (shifted | fillMask) : shifted;
                remaining_d = remAfter;
                if (remAfter == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            remaining_q <= '0;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_right_shift_unit.sv
// Scoreboard bench for right_shift_unit: stimulus pushes expected result and
// completion edge, an independent monitor pops and compares on every done pulse.
module tb_right_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] operand;
    logic [3:0]  amount;
    logic        arith;
    logic [15:0] result;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] res;
        int          doneEdge;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int          edgeCount;
    logic [15:0] lastResult;

    right_shift_unit #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .operand (operand),
        .amount  (amount),
        .arith   (arith),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCount = edgeCount + 1;

    // Reference: plain shift operators on the whole word.
    function automatic logic [15:0] refShift(input logic [15:0] op, input logic [3:0] amt, input logic ar);
        logic signed [15:0] s;
        if (ar) begin
            s = op;
            s = s >>> amt;
            return s;
        end
        return op >> amt;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at edge %0d", name, actual, expected, edgeCount);
        end
    endtask

    // Called at a negedge; waits for IDLE, issues one op and records its expected outcome.
    task automatic applyStimulus(input logic [15:0] op, input logic [3:0] amt, input logic ar);
        exp_t e;
        int   guard;
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
        start   = 1'b1;
        operand = op;
        amount  = amt;
        arith   = ar;
        e.res      = refShift(op, amt, ar);
        e.doneEdge = edgeCount + 1 + (int'(amt) + 2) / 3;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scrambles the inputs while the op is in flight; start is dropped as soon as IDLE is seen.
    task automatic finishOp(input logic holdStart);
        int guard;
        guard = 0;
        while (busy && guard < 40) begin
            start   = holdStart ? 1'b1 : 1'($urandom_range(0, 1));
            operand = 16'($urandom);
            amount  = 4'($urandom_range(0, 15));
            arith   = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (busy) checkOutput("op_timeout", 32'(busy), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding op; IDLE must hold the result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                checkOutput("done_has_pending_op", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("done_edge", 32'(edgeCount), 32'(e.doneEdge));
                    checkOutput("busy_in_done", 32'(busy), 32'd1);
                    lastResult = e.res;
                end
            end else if (!busy) begin
                checkOutput("idle_hold", 32'(result), 32'(lastResult));
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        edgeCount  = 0;
        lastResult = 16'h0000;
        rst_n      = 1'b0;
        start      = 1'b0;
        operand    = 16'h0000;
        amount     = 4'd0;
        arith      = 1'b0;

        #3;
        checkOutput("reset_result", 32'(result), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(16'hF000, 4'd4, 1'b1);
        finishOp(1'b0);
        applyStimulus(16'h8001, 4'd15, 1'b0);
        finishOp(1'b0);
        applyStimulus(16'h1234, 4'd0, 1'b0);
        finishOp(1'b0);
        applyStimulus(16'hABCD, 4'd7, 1'b0);
        finishOp(1'b1);
        applyStimulus(16'h8000, 4'd15, 1'b1);
        finishOp(1'b0);
        applyStimulus(16'h7FFF, 4'd3, 1'b1);
        finishOp(1'b0);

        $display("[TB] reset during shift");
        applyStimulus(16'h9ABC, 4'd15, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        lastResult = 16'h0000;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_result", 32'(result), 32'h0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h8421, 4'd5, 1'b0);
        finishOp(1'b0);

        $display("[TB] random back-to-back operations");
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            finishOp(1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
